life_sequencer: RTL and testbench
=================================

# life_sequencer

Command-driven controller for the toroidal Game of Life cell array. It loads an initial pattern serially and commits it to the array. It then issues generation steps (single, counted or free-running), detects still-life and extinction, and scans each resulting frame out bit-serially to the display/console path. It sits between the host/testbench command source and the `WIDTH`×`HEIGHT` cell array.

## Interface
- `WIDTH`, 16, columns of the array
- `HEIGHT`, 16, rows of the array
- `CELL_NUM`, `WIDTH*HEIGHT`, derived; do not override
- `GEN_W`, 16, width of the generation counter and the step count

- `clock`  in  1  system clock, all logic on posedge
- `reset`  in  1  synchronous, active-high
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid` and `cmd_ready` are both high
- `cmd_op`  in  2  0 `LOAD`, 1 `STEP`, 2 `RUN`, 3 `HALT`
- `cmd_count`  in  `GEN_W`  generation count for `STEP`
- `load_valid`  in  1  pattern bit offered
- `load_bit`  in  1  pattern bit; row-major, index 0 (row 0, column 0) first
- `load_ready`  out  1  pattern bit accepted
- `array_init`  out  `CELL_NUM`  pattern presented to the array
- `array_load`  out  1  1-cycle pulse; array shows `array_init` from the next cycle
- `array_step`  out  1  1-cycle pulse; array shows the next generation from the next cycle
- `array_states`  in  `CELL_NUM`  current generation from the array
- `disp_valid`  out  1  frame bit valid
- `disp_ready`  in  1  display sink accepts the bit
- `disp_bit`  out  1  cell state
- `disp_eol`  out  1  bit is the last column of a row
- `disp_eof`  out  1  bit is the last cell of the frame
- `gen_count`  out  `GEN_W`  generations since last load; saturates at all-ones
- `stable`  out  1  last step produced no change
- `extinct`  out  1  current generation has no live cells
- `busy`  out  1  state is not `IDLE`

## Operation
- States: `IDLE`, `LOAD`, `COMMIT`, `STEP`, `SETTLE`, `DISPLAY`.
- `cmd_ready` is 1 in `IDLE` and during a `RUN`; it is 0 in all other cases.
- `load_ready` is 1 only in `LOAD`.
- `LOAD` command:
  - The controller accepts `CELL_NUM` bits, writing each into `array_init[idx]` with `idx` running 0..`CELL_NUM`-1.
  - After the last bit it goes to `COMMIT`, which pulses `array_load` and clears `gen_count`, `stable` and `extinct`.
  - It then goes to `DISPLAY` (frame 0) and returns to `IDLE`.
- `STEP` command, count N:
  - N=0: display the current frame only, with no step.
  - Otherwise: loop `STEP`→`SETTLE` N times, then `DISPLAY`, then `IDLE`.
  - `STEP` asserts `array_step`, captures `array_states` into `prev`, and increments `gen_count`.
  - `SETTLE` sets `stable` = (`array_states` == `prev`) and `extinct` = (`array_states` == 0).
  - The loop ends early when `stable` or `extinct` is set.
- `RUN` command:
  - Loops `STEP`→`SETTLE`→`DISPLAY` indefinitely, displaying every generation.
  - It stops after the current frame's `disp_eof` transfer once either of these holds:
    - a `HALT` has been accepted during the run;
    - `stable` or `extinct` has been set.
  - Non-`HALT` commands accepted during `RUN` are discarded.
- `HALT` in `IDLE` is accepted and has no effect.
- `DISPLAY`:
  - `disp_bit` = `array_states[idx]`, with `idx` counting 0..`CELL_NUM`-1.
  - `disp_eol` = (`idx` % `WIDTH` == `WIDTH`-1).
  - `disp_eof` = (`idx` == `CELL_NUM`-1).
  - `idx` advances only on a `disp_valid`·`disp_ready` transfer.
  - All `disp_*` outputs stay stable while stalled.
- Flags `stable` and `extinct` are held until the next `SETTLE` or `COMMIT`.
- Reset:
  - State goes to `IDLE`. All outputs become 0, including `array_init`, `gen_count` and the flags.
  - A reset mid-`LOAD` discards partial data and issues no `array_load`.
  - A reset mid-`RUN`/`DISPLAY` drops the frame.
  - The controller never resets the array itself.

## Timing
- `LOAD` command accepted at cycle t → `load_ready`=1 from t+1.
- Last pattern bit accepted at t → `array_load`=1 at t+1 → `disp_valid`=1 at t+2.
- `STEP` accepted at t → `array_step` at t+1 → `SETTLE` flag update at t+2.
- When more generations remain, the next `array_step` follows at t+3; the step rate is 2 cycles per generation.
- Final `SETTLE` at s → `disp_valid` at s+1.
- With `disp_ready` held at 1, a frame takes exactly `CELL_NUM` cycles.
- Last display transfer at u → `IDLE` at u+1 (`busy`=0), or `array_step` at u+1 when `RUN` continues.
- `array_load` and `array_step` are never high in the same cycle, and are never high during `DISPLAY`.

## Test plan
- Blinker: `LOAD` a 16×16 pattern with row 5, cols 4–6 live, then `STEP` 1.
  - Frame 0 shows the horizontal blinker.
  - Frame 1 shows row 4–6 col 5 live; `gen_count`=1, `stable`=0, `extinct`=0.
  - 16 `disp_eol` and one `disp_eof` per frame.
- Block still life: 2×2 at rows 2–3, cols 2–3, then `STEP` 5.
  - Stops after one generation with `gen_count`=1, `stable`=1.
  - Exactly one `array_step` pulse.
- Extinction: a single live cell at (0,0), then `STEP` 3.
  - `extinct`=1 and `gen_count`=1; the frame is all dots.
- Wrap-around: a glider crossing the (15,15) corner under `RUN`, with `disp_ready` toggling 1,0,1,0.
  - Frame bits must not drop or duplicate.
  - After 64 generations the glider is back at its start position, shifted by 16 (mod 16).
  - `HALT` issued mid-frame → the run stops after that frame's `disp_eof`.
- Reset mid-`LOAD` after 100 bits: no `array_load` pulse; `array_init`=0; `load_ready`=0.
  - A subsequent full `LOAD` works normally.
- `STEP` 0 and saturation: `STEP` 0 displays one frame with no `array_step`.
  - With `GEN_W`=4, a `RUN` of a blinker for 20 generations → `gen_count` holds at 15.

Source files
------------

// File: rtl/life_sequencer_if.sv
// life_sequencer_if
//   Bundles every non-clock signal between the life_sequencer and its
//   environment: host command channel, serial pattern load channel, cell
//   array control/state bus, display stream and status flags.
//
//   slave  : used by the sequencer (takes commands, drives array/display/status)
//   master : used by the host / array / display side
//
//   Signals:
//     cmd_valid/cmd_ready/cmd_op/cmd_count   command handshake
//     load_valid/load_bit/load_ready         serial pattern load
//     array_init/array_load/array_step       pattern and strobes to the array
//     array_states                           current generation from the array
//     disp_valid/disp_ready/disp_bit/eol/eof frame scan-out stream
//     gen_count/stable/extinct/busy          status
interface life_sequencer_if #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int GEN_W  = 16
);
    localparam int CELL_NUM = WIDTH * HEIGHT;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [GEN_W-1:0]    cmd_count;
    logic                load_valid;
    logic                load_bit;
    logic                load_ready;
    logic [CELL_NUM-1:0] array_init;
    logic                array_load;
    logic                array_step;
    logic [CELL_NUM-1:0] array_states;
    logic                disp_valid;
    logic                disp_ready;
    logic                disp_bit;
    logic                disp_eol;
    logic                disp_eof;
    logic [GEN_W-1:0]    gen_count;
    logic                stable;
    logic                extinct;
    logic                busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, load_valid, load_bit,
               array_states, disp_ready,
        output cmd_ready, load_ready, array_init, array_load, array_step,
               disp_valid, disp_bit, disp_eol, disp_eof,
               gen_count, stable, extinct, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_count, load_valid, load_bit,
               array_states, disp_ready,
        input  cmd_ready, load_ready, array_init, array_load, array_step,
               disp_valid, disp_bit, disp_eol, disp_eof,
               gen_count, stable, extinct, busy
    );
endinterface

// File: rtl/life_sequencer.sv
// life_sequencer
//   Command-driven controller for a toroidal Game of Life cell array.
//   LOAD shifts a row-major pattern in serially and commits it to the array,
//   STEP advances N generations (stopping early on still-life/extinction),
//   RUN steps and displays until HALT or still-life/extinction. Every
//   resulting frame is scanned out bit-serially on the display stream.
//
//   Ports:
//     clock  system clock, posedge
//     reset  synchronous, active-high; returns to IDLE, clears all outputs
//     bus    life_sequencer_if.slave (command, load, array, display, status)
module life_sequencer #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int GEN_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    life_sequencer_if.slave  bus
);
    localparam int CELL_NUM = WIDTH * HEIGHT;
    localparam int IDX_W    = (CELL_NUM > 1) ? $clog2(CELL_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_NUM - 1);
    localparam logic [GEN_W-1:0] GEN_MAX  = '1;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_STEP = 2'd1;
    localparam logic [1:0] OP_RUN  = 2'd2;
    localparam logic [1:0] OP_HALT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_STEP,
        S_SETTLE,
        S_DISPLAY
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;      // shared by pattern load and frame scan
    logic [CELL_NUM-1:0] init_q;
    logic [CELL_NUM-1:0] prev_q;     // generation before the latest step
    logic [GEN_W-1:0]    gen_q;
    logic [GEN_W-1:0]    left_q;     // generations still to run for STEP
    logic                stable_q;
    logic                extinct_q;
    logic                run_q;
    logic                halt_q;

    logic cmd_ready;
    logic cmd_fire;
    logic halt_fire;
    logic disp_valid;
    logic disp_fire;
    logic now_stable;
    logic now_extinct;

    // Gated by reset so every output reads 0 while reset is held.
    assign cmd_ready   = ~reset & ((state_q == S_IDLE) | run_q);
    assign cmd_fire    = bus.cmd_valid & cmd_ready;
    assign halt_fire   = cmd_fire & (bus.cmd_op == OP_HALT);
    assign disp_valid  = (state_q == S_DISPLAY);
    assign disp_fire   = disp_valid & bus.disp_ready;
    assign now_stable  = (bus.array_states == prev_q);
    assign now_extinct = (bus.array_states == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            init_q    <= '0;
            gen_q     <= '0;
            left_q    <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
            run_q     <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            // Placed ahead of the case so the end-of-run clear below wins.
            if (run_q && halt_fire) begin
                halt_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (cmd_fire) begin
                        case (bus.cmd_op)
                            OP_LOAD: begin
                                idx_q   <= '0;
                                state_q <= S_LOAD;
                            end
                            OP_STEP: begin
                                idx_q   <= '0;
                                left_q  <= bus.cmd_count;
                                state_q <= (bus.cmd_count == '0) ? S_DISPLAY : S_STEP;
                            end
                            OP_RUN: begin
                                idx_q   <= '0;
                                run_q   <= 1'b1;
                                halt_q  <= 1'b0;
                                state_q <= S_STEP;
                            end
                            default: ;  // HALT while idle is a no-op
                        endcase
                    end
                end
                S_LOAD: begin
                    if (bus.load_valid) begin
                        init_q[idx_q] <= bus.load_bit;
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= S_COMMIT;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    gen_q     <= '0;
                    stable_q  <= 1'b0;
                    extinct_q <= 1'b0;
                    state_q   <= S_DISPLAY;
                end
                S_STEP: begin
                    prev_q <= bus.array_states;
                    if (gen_q != GEN_MAX) begin
                        gen_q <= gen_q + 1'b1;
                    end
                    state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    // Array already shows the new generation in this cycle.
                    stable_q  <= now_stable;
                    extinct_q <= now_extinct;
                    left_q    <= left_q - 1'b1;
                    if (run_q || now_stable || now_extinct || (left_q == GEN_W'(1))) begin
                        state_q <= S_DISPLAY;
                    end else begin
                        state_q <= S_STEP;
                    end
                end
                S_DISPLAY: begin
                    if (disp_fire) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
                            if (run_q && !halt_q && !halt_fire && !stable_q && !extinct_q) begin
                                state_q <= S_STEP;
                            end else begin
                                run_q   <= 1'b0;
                                halt_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.load_ready = (state_q == S_LOAD);
    assign bus.array_init = init_q;
    assign bus.array_load = (state_q == S_COMMIT);
    assign bus.array_step = (state_q == S_STEP);
    assign bus.disp_valid = disp_valid;
    assign bus.disp_bit   = disp_valid & bus.array_states[idx_q];
    assign bus.disp_eol   = disp_valid & ((int'(idx_q) % WIDTH) == (WIDTH - 1));
    assign bus.disp_eof   = disp_valid & (idx_q == LAST_IDX);
    assign bus.gen_count  = gen_q;
    assign bus.stable     = stable_q;
    assign bus.extinct    = extinct_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_life_sequencer.sv
module tb_life_sequencer;
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_STEP = 2'd1;
    localparam logic [1:0] OP_RUN  = 2'd2;
    localparam logic [1:0] OP_HALT = 2'd3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    life_sequencer_if #(.WIDTH(16), .HEIGHT(16), .GEN_W(16)) bus1 ();
    life_sequencer_if #(.WIDTH(16), .HEIGHT(16), .GEN_W(4))  bus2 ();

    life_sequencer #(.WIDTH(16), .HEIGHT(16), .GEN_W(16)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
    life_sequencer #(.WIDTH(16), .HEIGHT(16), .GEN_W(4))  dut2 (.clock(clock), .reset(reset), .bus(bus2));

    // Second instance (4-bit generation counter) runs in lockstep with the first.
    assign bus2.cmd_valid  = bus1.cmd_valid;
    assign bus2.cmd_op     = bus1.cmd_op;
    assign bus2.cmd_count  = bus1.cmd_count[3:0];
    assign bus2.load_valid = bus1.load_valid;
    assign bus2.load_bit   = bus1.load_bit;
    assign bus2.disp_ready = bus1.disp_ready;

    // Toroidal 16x16 Life array models
    function automatic logic [255:0] life_next(input logic [255:0] s);
        logic [255:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            cnt += int'(s[((r + dr + 16) % 16) * 16 + ((c + dc + 16) % 16)]);
                n[r*16+c] = (cnt == 3) || (cnt == 2 && s[r*16+c]);
            end
        end
        return n;
    endfunction

    logic [255:0] arr1 = '0;
    logic [255:0] arr2 = '0;
    always @(posedge clock) begin
        if (bus1.array_load) arr1 <= bus1.array_init;
        else if (bus1.array_step) arr1 <= life_next(arr1);
        if (bus2.array_load) arr2 <= bus2.array_init;
        else if (bus2.array_step) arr2 <= life_next(arr2);
    end
    assign bus1.array_states = arr1;
    assign bus2.array_states = arr2;

    // disp_ready: held high, or toggling 1,0,1,0 when rdy_toggle is set
    logic rdy_toggle = 1'b0;
    always @(posedge clock) begin
        #1;
        if (rdy_toggle) bus1.disp_ready = ~bus1.disp_ready;
        else            bus1.disp_ready = 1'b1;
    end

    // Frame capture and strobe monitor, sampled mid-cycle
    int frames = 0, pos = 0, eolc = 0, last_eol = 0, bad_frame = 0;
    int loads = 0, steps = 0, overlap = 0;
    logic [255:0] cur = '0, last_frame = '0;
    always @(negedge clock) begin
        if (bus1.array_load) loads++;
        if (bus1.array_step) steps++;
        if ((bus1.array_load && bus1.array_step) ||
            ((bus1.array_load || bus1.array_step) && bus1.disp_valid)) overlap++;
        if (bus1.disp_valid && bus1.disp_ready) begin
            cur[pos] = bus1.disp_bit;
            if (bus1.disp_eol) eolc++;
            if (bus1.disp_eof) begin
                if (pos != 255) bad_frame++;
                last_frame = cur;
                last_eol   = eolc;
                frames++;
                pos  = 0;
                eolc = 0;
            end else begin
                pos++;
                if (pos > 255) begin
                    bad_frame++;
                    pos = 0;
                end
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [15:0] cnt);
        int n;
        n = 0;
        bus1.cmd_valid = 1'b1;
        bus1.cmd_op    = op;
        bus1.cmd_count = cnt;
        @(negedge clock);
        while (!bus1.cmd_ready && n < 60000) begin
            n++;
            @(negedge clock);
        end
        chk("cmd_accept", bus1.cmd_ready, 1);
        cyc();
        bus1.cmd_valid = 1'b0;
    endtask

    task automatic load_bits(input logic [255:0] p, input int nbits);
        do_cmd(OP_LOAD, 16'd0);
        for (int i = 0; i < nbits; i++) begin
            bus1.load_valid = 1'b1;
            bus1.load_bit   = p[i];
            cyc();
        end
        bus1.load_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (bus1.busy && n < budget) begin
            n++;
            @(negedge clock);
        end
        chk("idle_timeout", bus1.busy, 0);
        cyc();
    endtask

    task automatic wait_frame_pos(input int target, input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (!(frames >= target && pos >= 20) && n < budget) begin
            n++;
            @(negedge clock);
        end
        chk("frame_wait_timeout", (frames >= target), 1);
    endtask

    initial begin
        logic [255:0] pb, pv, pk, ps, pg, pones;
        int s0, f0, l0;
        #900000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
        pb = '0; pv = '0; pk = '0; ps = '0; pg = '0; pones = '1;
    end

    initial begin
        logic [255:0] pb, pv, pk, ps, pg, pones;
        int s0, f0, l0;
        pb = '0; pb[84] = 1'b1; pb[85] = 1'b1; pb[86] = 1'b1;      // row 5, cols 4-6
        pv = '0; pv[69] = 1'b1; pv[85] = 1'b1; pv[101] = 1'b1;     // rows 4-6, col 5
        pk = '0; pk[34] = 1'b1; pk[35] = 1'b1; pk[50] = 1'b1; pk[51] = 1'b1;
        ps = '0; ps[0] = 1'b1;
        pg = '0; pg[222] = 1'b1; pg[239] = 1'b1; pg[253] = 1'b1; pg[254] = 1'b1; pg[255] = 1'b1;
        pones = '1;

        bus1.cmd_valid = 1'b0; bus1.cmd_op = 2'd0; bus1.cmd_count = '0;
        bus1.load_valid = 1'b0; bus1.load_bit = 1'b0;
        reset = 1'b1;
        repeat (3) cyc();

        // Reset state
        chk("rst_busy", bus1.busy, 0);
        chk("rst_cmd_ready", bus1.cmd_ready, 0);
        chk("rst_load_ready", bus1.load_ready, 0);
        chk("rst_array_init", bus1.array_init, 0);
        chk("rst_gen_count", bus1.gen_count, 0);
        chk("rst_disp_valid", bus1.disp_valid, 0);
        reset = 1'b0;
        cyc();
        chk("idle_cmd_ready", bus1.cmd_ready, 1);

        // Blinker: load, frame 0, then STEP 1
        load_bits(pb, 256);
        chk("load_pulse", bus1.array_load, 1);
        cyc();
        chk("load_to_disp", bus1.disp_valid, 1);
        chk("load_pulse_width", bus1.array_load, 0);
        wait_idle(1000);
        chk("blinker_f0", last_frame, pb);
        chk("blinker_f0_eol", last_eol, 16);
        s0 = steps;
        do_cmd(OP_STEP, 16'd1);
        chk("step_pulse", bus1.array_step, 1);
        cyc();
        chk("step_pulse_width", bus1.array_step, 0);
        cyc();
        chk("settle_to_disp", bus1.disp_valid, 1);
        wait_idle(1000);
        chk("blinker_f1", last_frame, pv);
        chk("blinker_f1_eol", last_eol, 16);
        chk("blinker_gen", bus1.gen_count, 1);
        chk("blinker_stable", bus1.stable, 0);
        chk("blinker_extinct", bus1.extinct, 0);
        chk("blinker_steps", steps - s0, 1);

        // HALT while idle
        do_cmd(OP_HALT, 16'd0);
        chk("halt_idle_busy", bus1.busy, 0);
        chk("halt_idle_gen", bus1.gen_count, 1);

        // Block still life, STEP 5 stops after one generation
        load_bits(pk, 256);
        wait_idle(1000);
        chk("block_gen_clear", bus1.gen_count, 0);
        s0 = steps;
        do_cmd(OP_STEP, 16'd5);
        wait_idle(2000);
        chk("block_gen", bus1.gen_count, 1);
        chk("block_stable", bus1.stable, 1);
        chk("block_extinct", bus1.extinct, 0);
        chk("block_steps", steps - s0, 1);
        chk("block_frame", last_frame, pk);

        // STEP 0: one frame, no step
        s0 = steps;
        f0 = frames;
        do_cmd(OP_STEP, 16'd0);
        chk("step0_disp", bus1.disp_valid, 1);
        wait_idle(1000);
        chk("step0_steps", steps - s0, 0);
        chk("step0_frames", frames - f0, 1);
        chk("step0_frame", last_frame, pk);
        chk("step0_gen", bus1.gen_count, 1);

        // Reset mid-LOAD after 100 bits
        l0 = loads;
        load_bits(pones, 100);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midload_init", bus1.array_init, 0);
        chk("midload_load_ready", bus1.load_ready, 0);
        chk("midload_busy", bus1.busy, 0);
        chk("midload_gen", bus1.gen_count, 0);
        repeat (3) cyc();
        chk("midload_no_pulse", loads - l0, 0);

        // Extinction: single cell, STEP 3
        load_bits(ps, 256);
        wait_idle(1000);
        chk("reload_pulse", loads - l0, 1);
        chk("single_f0", last_frame, ps);
        s0 = steps;
        do_cmd(OP_STEP, 16'd3);
        wait_idle(2000);
        chk("ext_flag", bus1.extinct, 1);
        chk("ext_stable", bus1.stable, 0);
        chk("ext_gen", bus1.gen_count, 1);
        chk("ext_steps", steps - s0, 1);
        chk("ext_frame", last_frame, 0);

        // Glider over the wrap corner, RUN with stalling display, HALT mid-frame 64
        load_bits(pg, 256);
        wait_idle(1000);
        f0 = frames;
        rdy_toggle = 1'b1;
        do_cmd(OP_RUN, 16'd0);
        chk("run_busy", bus1.busy, 1);
        wait_frame_pos(f0 + 63, 60000);
        do_cmd(OP_HALT, 16'd0);
        chk("halt_midframe_busy", bus1.busy, 1);
        wait_idle(3000);
        rdy_toggle = 1'b0;
        chk("glider_frames", frames - f0, 64);
        chk("glider_frame", last_frame, pg);
        chk("glider_gen", bus1.gen_count, 64);
        chk("glider_eol", last_eol, 16);
        chk("glider_stable", bus1.stable, 0);
        chk("frame_integrity", bad_frame, 0);

        // Saturation: RUN blinker 20 generations, 4-bit counter holds at 15
        load_bits(pb, 256);
        wait_idle(1000);
        f0 = frames;
        do_cmd(OP_RUN, 16'd0);
        wait_frame_pos(f0 + 19, 20000);
        do_cmd(OP_HALT, 16'd0);
        wait_idle(1000);
        chk("sat_frames", frames - f0, 20);
        chk("sat_gen16", bus1.gen_count, 20);
        chk("sat_gen4", bus2.gen_count, 15);
        chk("sat_frame", last_frame, pb);
        chk("strobe_overlap", overlap, 0);
        chk("final_integrity", bad_frame, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
